core_alu_sched: RTL
===================

Name: core_alu_sched

Overview:
Sequencer/arbiter that shares the single core_alu instance between two requesters: A (integer issue) and B (LSU address generation). It accepts one operation at a time over a valid/ready handshake and decodes its op index into the ALU's one-hot control lines. It holds operands for the ALU latency, captures the result, and returns it with the requester's tag over a valid/ready response channel. It sits between decode/issue and core_alu in the execute stage.

Parameters:
ALU_LAT, 2, cycles from alu_op assertion to alu_result valid (legal range 1..15)
TAG_W, 4, width of requester tag carried through to the response

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush  in  1  synchronous kill of any in-flight op
a_req_valid  in  1  requester A has an op
a_req_ready  out  1  A op accepted this cycle when valid&ready
a_op  in  6  op index (see Behaviour)
a_rs1, a_rs2, a_imm  in  32 each  operands for A
a_tag  in  TAG_W  A's tag
b_req_valid, b_req_ready, b_op, b_rs1, b_rs2, b_imm, b_tag  same as A, for requester B
alu_op  out  33  one-hot ALU control, order = op index
alu_rs1, alu_rs2, alu_imm  out  32 each  ALU operands
alu_result  in  32  ALU RESULT
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_src  out  1  0=A, 1=B
rsp_tag  out  TAG_W  tag of completed op
rsp_result  out  32  captured ALU result (0 on error)
rsp_err  out  1  illegal op index
busy  out  1  state != IDLE

Behaviour:
- Op index 0..32: ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI,ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,BEQ,BNE,BLT,BGE,BLTU,BGEU,LB,LH,LW,LBU,LHU,SB,SH,SW. Index 33..63 is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and goes only to the arbitration winner; both readys are 0 when flush=1.
  - Round-robin: if both are valid, grant the requester not granted last. last_grant resets to B, so A wins first.
  - On accept: register op, operands, tag, src.
  - Legal op: go to EXEC and load the counter with ALU_LAT-1.
  - Illegal op: go directly to RESP with rsp_err=1 and rsp_result=0. alu_op is never asserted.
- EXEC:
  - alu_op = one-hot(op); alu_rs1/rs2/imm = registered operands, held stable.
  - Counter decrements each cycle. In the cycle it reads 0, capture alu_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* fields are held stable until rsp_ready=1.
  - On handshake, go to IDLE. No same-cycle accept: the next accept happens in IDLE at the earliest.
- Outside EXEC: alu_op=0 and alu operands=0. Both req_ready=0 in EXEC and RESP.
- Latency (legal op, rsp_ready=1): rsp_valid rises ALU_LAT+1 cycles after the accept edge. Throughput is one op per ALU_LAT+2 cycles.
- Illegal op: rsp_valid rises 1 cycle after accept.
- flush:
  - Any state → IDLE next cycle. The in-flight op is dropped with no response.
  - rsp_valid and alu_op are 0 from the next cycle.
  - last_grant is unchanged.
  - flush overrides a simultaneous rsp handshake: the response counts as not consumed.
- rst (any state, including mid-EXEC/RESP): next cycle state=IDLE; all outputs 0 (readys follow IDLE arbitration once rst=0); last_grant=B; counter=0. rst has priority over flush.

Test Plan:
1. ADDI (idx 0) from A only: rs1=0x000000F0, imm=0x0000000F, tag=3, ALU_LAT=2 → alu_op bit0 high for exactly 2 cycles; rsp_valid 3 cycles after accept; rsp_result=0x000000FF, rsp_src=0, rsp_tag=3, rsp_err=0.
2. Arbitration: after reset, A=SUB(idx10, 0x09439AD4−0x00531794) and B=ADD(idx9, same operands) both valid → A served first, result 0x08F08340; then B, result 0x0996B268; then both valid again → A granted.
3. Backpressure: B=SRAI (idx8, rs1=0x8E5460F5, imm=4); rsp_ready held low 5 cycles after rsp_valid → rsp fields stable at 0xF8E5460F; a/b_req_ready=0 throughout; IDLE one cycle after the handshake.
4. Illegal op: A op=40 → alu_op stays 0; rsp_valid 1 cycle after accept with rsp_err=1, rsp_result=0.
5. flush in the first EXEC cycle of A's SLT → no response; alu_op=0 next cycle. Then B SLTU (idx13, rs1=0x86C160F0, rs2=0x70F0680F) is accepted → rsp_result=0.
6. rst asserted during RESP with rsp_ready=0 → next cycle rsp_valid=0, busy=0, alu_op=0. First op after reset is granted to A when both are valid.

Source files
------------

// File: rtl/core_alu_sched.sv
// Shares one core_alu between requester A (integer issue) and B (LSU address gen):
// round-robin accept, one-hot op decode, latency hold, and a held valid/ready response.
module core_alu_sched #(
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [5:0]       a_op,
    input  logic [31:0]      a_rs1,
    input  logic [31:0]      a_rs2,
    input  logic [31:0]      a_imm,
    input  logic [TAG_W-1:0] a_tag,

    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [5:0]       b_op,
    input  logic [31:0]      b_rs1,
    input  logic [31:0]      b_rs2,
    input  logic [31:0]      b_imm,
    input  logic [TAG_W-1:0] b_tag,

    output logic [32:0]      alu_op,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    output logic [31:0]      alu_imm,
    input  logic [31:0]      alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [5:0] LAST_LEGAL_OP = 6'd32;
    localparam logic [3:0] CNT_INIT      = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;   // 0 = A, 1 = B
    logic [5:0]       op_q;
    logic [31:0]      rs1_q, rs2_q, imm_q;
    logic [TAG_W-1:0] tag_q;
    logic             src_q;
    logic [3:0]       cnt;
    logic [31:0]      result_q;
    logic             err_q;

    logic             grant_a, grant_b, can_accept, accept, sel_src, op_legal;
    logic [5:0]       sel_op;

    // Arbitration and accept decode: readys depend only on current inputs and state.
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_a     = a_req_valid && (!b_req_valid || last_grant);
        grant_b     = b_req_valid && (!a_req_valid || !last_grant);
        can_accept  = (state == IDLE) && !flush && !rst;
        a_req_ready = can_accept && grant_a;
        b_req_ready = can_accept && grant_b;
        accept      = (a_req_valid && a_req_ready) || (b_req_valid && b_req_ready);
        sel_src     = b_req_ready;
        sel_op      = sel_src ? b_op : a_op;
        op_legal    = (sel_op <= LAST_LEGAL_OP);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = op_legal ? EXEC : RESP;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // flush wins over everything, including a same-cycle response handshake
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        alu_op     = '0;
        alu_rs1    = '0;
        alu_rs2    = '0;
        alu_imm    = '0;
        if (state == EXEC) begin
            alu_op  = 33'd1 << op_q;
            alu_rs1 = rs1_q;
            alu_rs2 = rs2_q;
            alu_imm = imm_q;
        end
        rsp_valid  = (state == RESP);
        rsp_src    = rsp_valid && src_q;
        rsp_tag    = rsp_valid ? tag_q : '0;
        rsp_result = rsp_valid ? result_q : '0;
        rsp_err    = rsp_valid && err_q;
        busy       = (state != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            tag_q      <= '0;
            src_q      <= 1'b0;
            cnt        <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= sel_op;
                rs1_q      <= sel_src ? b_rs1 : a_rs1;
                rs2_q      <= sel_src ? b_rs2 : a_rs2;
                imm_q      <= sel_src ? b_imm : a_imm;
                tag_q      <= sel_src ? b_tag : a_tag;
                src_q      <= sel_src;
                last_grant <= sel_src;
                cnt        <= CNT_INIT;
                result_q   <= '0;
                err_q      <= !op_legal;
            end else if (state == EXEC) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else             result_q <= alu_result;
            end
        end
    end

endmodule
